// File: rtl/button_bank.sv
// button_bank: N-channel push-button conditioner.
// Each channel runs a 2-flop synchroniser and a sample flop into a
// saturating-run debounce filter, then derives registered press/release
// pulses and optional hold-to-auto-repeat pulses.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active-low
//   in        raw asynchronous button inputs, bit i = channel i
//   level     debounced level per channel
//   press     one-cycle pulse in the first cycle level[i] is high
//   rel       one-cycle pulse in the first cycle level[i] is low
//   rpt       one-cycle auto-repeat pulse while a button is held
//   any_press OR of press, aligned with press
module button_bank #(
  parameter int unsigned N             = 4,
  parameter int unsigned CNT_W         = 4,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic [N-1:0] rpt,
  output logic         any_press
);

  localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HC_W = $clog2(HMAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } hstate_t;

  logic [N-1:0] rise_c;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic             sync1, sync2, samp;
    logic             lvl, press_q, rel_q;
    logic [CNT_W-1:0] cnt;
    logic             flip_c, fall_c;

    // Level toggles once the run of mismatching samples reaches terminal count
    assign flip_c    = (samp != lvl) && (cnt == CNT_MAX);
    assign rise_c[i] = flip_c & ~lvl;
    assign fall_c    = flip_c & lvl;

    // Synchroniser, sample stage, debounce filter and edge pulses
    always_ff @(posedge clk) begin
      if (!rst) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        samp    <= 1'b0;
        cnt     <= '0;
        lvl     <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync1   <= in[i];
        sync2   <= sync1;
        samp    <= sync2;
        press_q <= rise_c[i];
        rel_q   <= fall_c;
        if (samp == lvl) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign level[i] = lvl;
    assign press[i] = press_q;
    assign rel[i]   = rel_q;

    if (REPEAT_EN) begin : g_rpt
      hstate_t         st, st_n;
      logic [HC_W-1:0] hcnt, hcnt_n;
      logic            rpt_q, rpt_n;

      // Hold/repeat state register
      always_ff @(posedge clk) begin
        if (!rst) begin
          st    <= IDLE;
          hcnt  <= '0;
          rpt_q <= 1'b0;
        end else begin
          st    <= st_n;
          hcnt  <= hcnt_n;
          rpt_q <= rpt_n;
        end
      end

      // Hold/repeat next state; a falling level wins over a due repeat
      always_comb begin
        st_n   = st;
        hcnt_n = hcnt;
        rpt_n  = 1'b0;
        if (fall_c) begin
          st_n   = IDLE;
          hcnt_n = '0;
        end else begin
          case (st)
            IDLE: begin
              if (rise_c[i]) begin
                st_n   = HOLD;
                hcnt_n = HC_W'(1);
              end
            end
            HOLD: begin
              if (hcnt == HC_W'(HOLD_CYCLES)) begin
                rpt_n  = 1'b1;
                st_n   = RPT;
                hcnt_n = HC_W'(1);
              end else begin
                hcnt_n = hcnt + HC_W'(1);
              end
            end
            RPT: begin
              if (hcnt == HC_W'(REPEAT_CYCLES)) begin
                rpt_n  = 1'b1;
                hcnt_n = HC_W'(1);
              end else begin
                hcnt_n = hcnt + HC_W'(1);
              end
            end
            default: begin
              st_n   = IDLE;
              hcnt_n = '0;
            end
          endcase
        end
      end

      assign rpt[i] = rpt_q;
    end else begin : g_norpt
      assign rpt[i] = 1'b0;
    end
  end

  // any_press is registered from the same rise events that feed press
  always_ff @(posedge clk) begin
    if (!rst) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |rise_c;
    end
  end

endmodule

// File: tb/tb_button_bank.sv
module tb_button_bank;

  localparam int H = 8;
  localparam int R = 4;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [3:0] level, press, rel, rpt;
  logic       any_press;
  logic [3:0] level2, press2, rel2, rpt2;
  logic       any2;

  button_bank #(.N(4), .CNT_W(4), .REPEAT_EN(1'b1), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) u_dut (
    .clk(clk), .rst(rst), .in(in), .level(level), .press(press), .rel(rel),
    .rpt(rpt), .any_press(any_press)
  );

  button_bank #(.N(4), .CNT_W(4), .REPEAT_EN(1'b0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) u_norpt (
    .clk(clk), .rst(rst), .in(in), .level(level2), .press(press2), .rel(rel2),
    .rpt(rpt2), .any_press(any2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: history of captured inputs, level flips when the last
  // 16 samples seen by the filter all disagree with it; repeats are timed
  // from the press edge with plain arithmetic.
  logic [3:0] inh[$];
  logic [3:0] seen[$];
  logic [3:0] m_level, m_press, m_rel, m_rpt;
  logic       m_any;
  int         since[4];
  bit         act[4];
  int         ec = 0;
  bit         mv = 0;
  logic [3:0] s;
  bit         all_diff, rise, fall;

  always @(posedge clk) begin
    mv = 1;
    if (!rst) begin
      inh.delete();
      seen.delete();
      m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0; m_any = 1'b0;
      for (int c = 0; c < 4; c++) begin act[c] = 0; since[c] = 0; end
      ec = 0;
    end else begin
      ec++;
      s = (inh.size() >= 3) ? inh[inh.size()-3] : 4'h0;
      inh.push_back(in);
      if (inh.size() > 8) void'(inh.pop_front());
      seen.push_back(s);
      if (seen.size() > 20) void'(seen.pop_front());
      for (int c = 0; c < 4; c++) begin
        all_diff = (seen.size() >= 16);
        for (int k = 0; k < 16 && all_diff; k++)
          if (seen[seen.size()-1-k][c] == m_level[c]) all_diff = 0;
        rise = all_diff && !m_level[c];
        fall = all_diff && m_level[c];
        m_press[c] = rise;
        m_rel[c]   = fall;
        m_rpt[c]   = 1'b0;
        if (all_diff) m_level[c] = ~m_level[c];
        if (fall) begin
          act[c] = 0;
        end else if (rise) begin
          act[c] = 1;
          since[c] = 0;
        end else if (act[c]) begin
          since[c]++;
          if (since[c] == H || (since[c] > H && (since[c] - H) % R == 0)) m_rpt[c] = 1'b1;
        end
      end
      m_any = |m_press;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (mv) begin
      chk("level", level, m_level);
      chk("press", press, m_press);
      chk("release", rel, m_rel);
      chk("rpt", rpt, m_rpt);
      chk("any_press", {3'b0, any_press}, {3'b0, m_any});
      chk("norpt_level", level2, m_level);
      chk("norpt_press", press2, m_press);
      chk("norpt_release", rel2, m_rel);
      chk("norpt_rpt", rpt2, 4'h0);
      chk("norpt_any", {3'b0, any2}, {3'b0, m_any});
    end
  end

  task automatic wait_edge(input int n);
    int guard = 0;
    while (ec < n) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 5000) begin
        n_bad++;
        $display("FAIL wait_edge: got ec=%0d expected %0d", ec, n);
        return;
      end
    end
  endtask

  initial begin
    int e;
    rst = 1'b0;
    in  = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_level", level, 4'h0);
    chk("lit_rst_press", press, 4'h0);
    chk("lit_rst_release", rel, 4'h0);
    chk("lit_rst_rpt", rpt, 4'h0);
    chk("lit_rst_any", {3'b0, any_press}, 4'h0);
    rst = 1'b1;

    // All channels pressed out of reset: level at edge 19, repeats at +8/+4
    wait_edge(18); chk("lit_lvl18", level, 4'h0);
    wait_edge(19); chk("lit_lvl19", level, 4'hF);
    chk("lit_press19", press, 4'hF);
    chk("lit_any19", {3'b0, any_press}, 4'h1);
    wait_edge(20); chk("lit_press20", press, 4'h0);
    chk("lit_any20", {3'b0, any_press}, 4'h0);
    wait_edge(26); chk("lit_rpt26", rpt, 4'h0);
    wait_edge(27); chk("lit_rpt27", rpt, 4'hF);
    wait_edge(31); chk("lit_rpt31", rpt, 4'hF);
    wait_edge(32); in = 4'h0;
    wait_edge(47); chk("lit_rpt47", rpt, 4'hF);
    wait_edge(50); chk("lit_lvl50", level, 4'hF);
    // Fall lands on a due repeat: release only
    wait_edge(51); chk("lit_lvl51", level, 4'h0);
    chk("lit_rel51", rel, 4'hF);
    chk("lit_rpt51", rpt, 4'h0);
    wait_edge(52); chk("lit_rel52", rel, 4'h0);

    // Glitch rejection on ch0
    wait_edge(60); in[0] = 1'b1;
    wait_edge(70); in[0] = 1'b0;
    wait_edge(71); in[0] = 1'b1;
    wait_edge(81); in[0] = 1'b0;
    wait_edge(100); chk("lit_glitch_lvl", level, 4'h0);
    in[0] = 1'b1;
    wait_edge(118); chk("lit_ch0_lvl118", level, 4'h0);
    wait_edge(119); chk("lit_ch0_press", press, 4'h1);
    wait_edge(130); in[0] = 1'b0;
    wait_edge(148); chk("lit_ch0_lvl148", level, 4'h1);
    wait_edge(149); chk("lit_ch0_rel", rel, 4'h1);
    chk("lit_ch0_lvl149", level, 4'h0);

    // Bounce then settle on ch2
    wait_edge(160);
    for (int k = 0; k < 14; k++) begin
      in[2] = ~in[2];
      wait_edge(ec + 3);
    end
    e = ec;
    in[2] = 1'b1;
    wait_edge(e + 18); chk("lit_ch2_lvl_pre", level, 4'h0);
    wait_edge(e + 19); chk("lit_ch2_lvl", level, 4'h4);
    chk("lit_ch2_press", press, 4'h4);
    wait_edge(230); in[2] = 1'b0;

    // Auto-repeat, release collision and re-press on ch1
    wait_edge(260); in[1] = 1'b1;
    wait_edge(279); chk("lit_ch1_press", press, 4'h2);
    wait_edge(287); chk("lit_ch1_rpt287", rpt, 4'h2);
    wait_edge(291); chk("lit_ch1_rpt291", rpt, 4'h2);
    wait_edge(295); chk("lit_ch1_rpt295", rpt, 4'h2);
    wait_edge(296); in[1] = 1'b0;
    wait_edge(311); chk("lit_ch1_rpt311", rpt, 4'h2);
    wait_edge(315); chk("lit_ch1_rel", rel, 4'h2);
    chk("lit_ch1_rpt315", rpt, 4'h0);
    wait_edge(330); in[1] = 1'b1;
    wait_edge(349); chk("lit_ch1_repress", press, 4'h2);
    wait_edge(356); chk("lit_ch1_rpt356", rpt, 4'h0);
    wait_edge(357); chk("lit_ch1_rpt357", rpt, 4'h2);

    // Reset while repeating; button still held gives a fresh press
    wait_edge(370);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_midrst_level", level, 4'h0);
    chk("lit_midrst_rpt", rpt, 4'h0);
    rst = 1'b1;
    wait_edge(18); chk("lit_post_lvl18", level, 4'h0);
    wait_edge(19); chk("lit_post_press", press, 4'h2);
    wait_edge(27); chk("lit_post_rpt", rpt, 4'h2);

    // Long hold: repeat-less build never pulses rpt
    wait_edge(40); in = 4'hF;
    wait_edge(2060);
    chk("lit_long_norpt", rpt2, 4'h0);
    chk("lit_long_lvl2", level2, 4'hF);
    in = 4'h0;
    wait_edge(2090);
    chk("lit_end_lvl", level, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
